branch_hazard_unit: RTL and testbench



---
 rtl/branch_hazard_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_hazard_unit.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_hazard_unit
// Description : ID-stage branch/jump control for a 5-stage MIPS pipeline.
//               Stalls a branch or jr whose source register is still being
//               produced in EX or MEM, selects the decode-stage forwarding
//               path, resolves the branch and redirects the PC.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_hazard_unit #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] FUNCT_JR = 6'b001000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_BNE   = 6'b000101,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_JAL   = 6'b000011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        cmp_eq,
    input  logic        ex_regWrite,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_rd,
    input  logic        mem_regWrite,
    input  logic        mem_memRead,
    input  logic [4:0]  mem_rd,
    input  logic        wb_regWrite,
    input  logic [4:0]  wb_rd,
    output logic [1:0]  forbranchA,
    output logic [1:0]  forbranchB,
    output logic [1:0]  PCsrc,
    output logic        stall,
    output logic        flush_ifid,
    output logic [1:0]  stall_cnt
);

    localparam logic [1:0] c_PC_SEQ    = 2'b00;
    localparam logic [1:0] c_PC_JUMP   = 2'b01;
    localparam logic [1:0] c_PC_BRANCH = 2'b10;
    localparam logic [1:0] c_PC_JR     = 2'b11;

    localparam logic [1:0] c_FWD_REG   = 2'b00;
    localparam logic [1:0] c_FWD_WB    = 2'b01;
    localparam logic [1:0] c_FWD_EXOUT = 2'b10;

    // Countdown state: 0 means RUN, nonzero means stall cycles still owed
    // after the current one.
    localparam logic [1:0] c_RUN       = 2'd0;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_is_beq;
    logic       w_is_bne;
    logic       w_is_br;
    logic       w_is_jr;
    logic       w_is_j;
    logic       w_haz_ex;
    logic       w_haz_mem;
    logic       w_taken;
    logic       w_unused_bits;

    logic [1:0] r_cnt;
    logic [1:0] w_cnt_next;
    logic [1:0] w_depth;
    logic       w_stall;
    logic       w_flush;
    logic [1:0] w_pcsrc;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_opcode = inst[31:26];
    assign w_funct  = inst[5:0];
    assign w_rs     = inst[25:21];
    assign w_rt     = inst[20:16];
    assign w_is_beq = (w_opcode == OP_BEQ);
    assign w_is_bne = (w_opcode == OP_BNE);
    assign w_is_br  = w_is_beq | w_is_bne;
    assign w_is_jr  = (w_opcode == OP_RTYPE) && (w_funct == FUNCT_JR);
    assign w_is_j   = (w_opcode == OP_J) || (w_opcode == OP_JAL);
    assign w_taken  = (w_is_beq && cmp_eq) || (w_is_bne && !cmp_eq);

    // Immediate/shamt bits play no part in hazard or branch control.
    assign w_unused_bits = ^inst[15:6];

    // True when a producer register matches a source this instruction needs.
    function automatic logic needs_match(input logic [4:0] prod);
        logic m_rs;
        logic m_rt;
        m_rs = (w_is_br || w_is_jr) && (w_rs != 5'd0) && (prod == w_rs);
        m_rt = w_is_br && (w_rt != 5'd0) && (prod == w_rt);
        return m_rs || m_rt;
    endfunction

    // Decode-stage operand source: EX/MEM ALU result beats the WB value.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = c_FWD_REG;
        if (mem_regWrite && !mem_memRead && (mem_rd == src) && (src != 5'd0))
            sel = c_FWD_EXOUT;
        else if (wb_regWrite && (wb_rd == src) && (src != 5'd0))
            sel = c_FWD_WB;
        return sel;
    endfunction

    assign w_haz_ex  = ex_regWrite && (ex_rd != 5'd0) && needs_match(ex_rd);
    assign w_haz_mem = mem_regWrite && mem_memRead && (mem_rd != 5'd0) &&
                       needs_match(mem_rd);

    assign w_fwd_a = fwd_sel(w_rs);
    assign w_fwd_b = w_is_br ? fwd_sel(w_rt) : c_FWD_REG;

    // Countdown register; async reset returns to RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= c_RUN;
        else
            r_cnt <= w_cnt_next;
    end

    // Next-state and resolve logic. w_depth is the number of stall cycles
    // remaining including the current one; the register keeps the remainder.
    always_comb begin
        w_cnt_next = r_cnt;
        w_depth    = 2'd0;
        w_stall    = 1'b0;
        w_flush    = 1'b0;
        w_pcsrc    = c_PC_SEQ;
        if (r_cnt != c_RUN) begin
            w_depth    = r_cnt;
            w_stall    = 1'b1;
            w_cnt_next = r_cnt - 2'd1;
        end else if (w_is_br || w_is_jr) begin
            if (w_haz_ex && ex_memRead)
                w_depth = 2'd2;
            else if (w_haz_ex || w_haz_mem)
                w_depth = 2'd1;
            if (w_depth != 2'd0) begin
                w_stall    = 1'b1;
                w_cnt_next = w_depth - 2'd1;
            end else if (w_is_jr) begin
                w_pcsrc = c_PC_JR;
                w_flush = 1'b1;
            end else if (w_taken) begin
                w_pcsrc = c_PC_BRANCH;
                w_flush = 1'b1;
            end
        end else if (w_is_j) begin
            w_pcsrc = c_PC_JUMP;
            w_flush = 1'b1;
        end
    end

    // Output drive; reset forces every output low without waiting for a clock.
    always_comb begin
        forbranchA = 2'b00;
        forbranchB = 2'b00;
        PCsrc      = 2'b00;
        stall      = 1'b0;
        flush_ifid = 1'b0;
        stall_cnt  = 2'b00;
        if (!reset) begin
            forbranchA = w_fwd_a;
            forbranchB = w_fwd_b;
            PCsrc      = w_pcsrc;
            stall      = w_stall;
            flush_ifid = w_flush;
            stall_cnt  = w_depth;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_hazard_unit
// Description : Scoreboard bench for branch_hazard_unit. Each scenario task
//               drives rows, pushes the expected outputs, and compares them
//               against the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_hazard_unit;

    localparam logic [5:0] c_OP_BEQ = 6'b000100;
    localparam logic [5:0] c_OP_BNE = 6'b000101;
    localparam logic [5:0] c_OP_J   = 6'b000010;
    localparam logic [5:0] c_OP_JAL = 6'b000011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic        cmp_eq;
    logic        ex_regWrite, ex_memRead;
    logic [4:0]  ex_rd;
    logic        mem_regWrite, mem_memRead;
    logic [4:0]  mem_rd;
    logic        wb_regWrite;
    logic [4:0]  wb_rd;
    logic [1:0]  forbranchA, forbranchB, PCsrc, stall_cnt;
    logic        stall, flush_ifid;
    logic [9:0]  obs;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];

    typedef struct packed {
        logic [31:0] inst;
        logic        cmp;
        logic        ex_rw;
        logic        ex_mr;
        logic [4:0]  ex_rd;
        logic        mem_rw;
        logic        mem_mr;
        logic [4:0]  mem_rd;
        logic        wb_rw;
        logic [4:0]  wb_rd;
    } stim_t;

    always #5 clk = ~clk;

    branch_hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .inst         (inst),
        .cmp_eq       (cmp_eq),
        .ex_regWrite  (ex_regWrite),
        .ex_memRead   (ex_memRead),
        .ex_rd        (ex_rd),
        .mem_regWrite (mem_regWrite),
        .mem_memRead  (mem_memRead),
        .mem_rd       (mem_rd),
        .wb_regWrite  (wb_regWrite),
        .wb_rd        (wb_rd),
        .forbranchA   (forbranchA),
        .forbranchB   (forbranchB),
        .PCsrc        (PCsrc),
        .stall        (stall),
        .flush_ifid   (flush_ifid),
        .stall_cnt    (stall_cnt)
    );

    assign obs = {forbranchA, forbranchB, PCsrc, stall, flush_ifid, stall_cnt};

    function automatic logic [31:0] beq(input logic [4:0] rs, input logic [4:0] rt);
        return {c_OP_BEQ, rs, rt, 16'h0004};
    endfunction

    function automatic logic [31:0] bne(input logic [4:0] rs, input logic [4:0] rt);
        return {c_OP_BNE, rs, rt, 16'h0008};
    endfunction

    function automatic logic [31:0] jr(input logic [4:0] rs);
        return {6'b000000, rs, 15'd0, 6'b001000};
    endfunction

    function automatic logic [31:0] jmp(input logic [5:0] op, input logic [4:0] rt_field);
        return {op, 5'd0, rt_field, 16'h0040};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic stim_t mk(input logic [31:0] i, input logic c,
                                 input logic erw, input logic emr, input logic [4:0] erd,
                                 input logic mrw, input logic mmr, input logic [4:0] mrd,
                                 input logic wrw, input logic [4:0] wrd);
        stim_t s;
        s.inst = i;   s.cmp = c;
        s.ex_rw = erw;  s.ex_mr = emr;  s.ex_rd = erd;
        s.mem_rw = mrw; s.mem_mr = mmr; s.mem_rd = mrd;
        s.wb_rw = wrw;  s.wb_rd = wrd;
        return s;
    endfunction

    // Expected output vector {forbranchA, forbranchB, PCsrc, stall, flush, stall_cnt}.
    function automatic logic [9:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic [1:0] pc, input logic st,
                                      input logic fl, input logic [1:0] cnt);
        return {fa, fb, pc, st, fl, cnt};
    endfunction

    task automatic apply(input stim_t s, input logic [9:0] e, input string n);
        inst         = s.inst;
        cmp_eq       = s.cmp;
        ex_regWrite  = s.ex_rw;
        ex_memRead   = s.ex_mr;
        ex_rd        = s.ex_rd;
        mem_regWrite = s.mem_rw;
        mem_memRead  = s.mem_mr;
        mem_rd       = s.mem_rd;
        wb_regWrite  = s.wb_rw;
        wb_rd        = s.wb_rd;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic test_reset();
        stim_t      s[2];
        logic [9:0] want;
        string      nm;
        s[0] = mk(beq(5'd3, 5'd0), 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3);
        s[1] = mk(jr(5'd31),       1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd31, 1'b1, 5'd31);
        for (int i = 0; i < 2; i++) begin
            apply(s[i], 10'd0, $sformatf("reset_hold_%0d", i));
            @(negedge clk);
            want = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL %s: got=%b want=%b", nm, obs, want);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_no_hazard();
        stim_t      s[8];
        logic [9:0] e[8];
        logic [9:0] want;
        string      nm;
        s[0] = mk(beq(5'd1, 5'd2), 1'b1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        e[0] = ev(2'b00, 2'b00, 2'b10, 0, 1, 2'd0);
        s[1] = mk(beq(5'd1, 5'd2), 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        e[1] = ev(2'b00, 2'b00, 2'b00, 0, 0, 2'd0);
        s[2] = mk(bne(5'd1, 5'd2), 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        e[2] = ev(2'b00, 2'b00, 2'b10, 0, 1, 2'd0);
        s[3] = mk(bne(5'd1, 5'd2), 1'b1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        e[3] = ev(2'b00, 2'b00, 2'b00, 0, 0, 2'd0);
        s[4] = mk(jmp(c_OP_J, 5'd0), 1'b0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        e[4] = ev(2'b00, 2'b00, 2'b01, 0, 1, 2'd0);
        s[5] = mk(jmp(c_OP_JAL, 5'd5), 1'b1, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd5);
        e[5] = ev(2'b00, 2'b00, 2'b01, 0, 1, 2'd0);
        s[6] = mk(add(5'd1, 5'd2, 5'd3), 1'b1, 1, 1, 5'd1, 0, 0, 5'd0, 0, 5'd0);
        e[6] = ev(2'b00, 2'b00, 2'b00, 0, 0, 2'd0);
        s[7] = mk(beq(5'd0, 5'd0), 1'b1, 1, 0, 5'd0, 0, 0, 5'd0, 1, 5'd0);
        e[7] = ev(2'b00, 2'b00, 2'b10, 0, 1, 2'd0);
        for (int i = 0; i < 8; i++) begin
            apply(s[i], e[i], $sformatf("no_hazard_%0d", i));
            @(negedge clk);
            want = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL %s: got=%b want=%b", nm, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forwarding();
        stim_t      s[4];
        logic [9:0] e[4];
        logic [9:0] want;
        string      nm;
        s[0] = mk(beq(5'd5, 5'd6), 1'b1, 0, 0, 5'd0, 1, 0, 5'd6, 1, 5'd5);
        e[0] = ev(2'b01, 2'b10, 2'b10, 0, 1, 2'd0);
        s[1] = mk(beq(5'd7, 5'd7), 1'b0, 0, 0, 5'd0, 1, 0, 5'd7, 1, 5'd7);
        e[1] = ev(2'b10, 2'b10, 2'b00, 0, 0, 2'd0);
        s[2] = mk(bne(5'd9, 5'd10), 1'b0, 0, 0, 5'd0, 0, 0, 5'd9, 0, 5'd10);
        e[2] = ev(2'b00, 2'b00, 2'b10, 0, 1, 2'd0);
        s[3] = mk(add(5'd12, 5'd13, 5'd1), 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd12);
        e[3] = ev(2'b01, 2'b00, 2'b00, 0, 0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i], $sformatf("forward_%0d", i));
            @(negedge clk);
            want = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL %s: got=%b want=%b", nm, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_hazard();
        stim_t      s[6];
        logic [9:0] e[6];
        logic [9:0] want;
        string      nm;
        s[0] = mk(beq(5'd3, 5'd0), 1'b0, 1, 0, 5'd3, 0, 0, 5'd0, 0, 5'd0);
        e[0] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd1);
        s[1] = mk(beq(5'd3, 5'd0), 1'b0, 0, 0, 5'd0, 1, 0, 5'd3, 0, 5'd0);
        e[1] = ev(2'b10, 2'b00, 2'b00, 0, 0, 2'd0);
        s[2] = mk(bne(5'd0, 5'd9), 1'b1, 1, 0, 5'd9, 0, 0, 5'd0, 0, 5'd0);
        e[2] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd1);
        s[3] = mk(bne(5'd0, 5'd9), 1'b1, 0, 0, 5'd0, 1, 0, 5'd9, 0, 5'd0);
        e[3] = ev(2'b00, 2'b10, 2'b00, 0, 0, 2'd0);
        s[4] = mk(beq(5'd3, 5'd0), 1'b1, 0, 0, 5'd3, 0, 0, 5'd0, 0, 5'd0);
        e[4] = ev(2'b00, 2'b00, 2'b10, 0, 1, 2'd0);
        s[5] = mk(beq(5'd11, 5'd0), 1'b1, 0, 0, 5'd0, 1, 0, 5'd11, 0, 5'd0);
        e[5] = ev(2'b10, 2'b00, 2'b10, 0, 1, 2'd0);
        for (int i = 0; i < 6; i++) begin
            apply(s[i], e[i], $sformatf("alu_hazard_%0d", i));
            @(negedge clk);
            want = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL %s: got=%b want=%b", nm, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_hazard();
        stim_t      s[3];
        logic [9:0] e[3];
        logic [9:0] want;
        string      nm;
        s[0] = mk(bne(5'd4, 5'd5), 1'b0, 1, 1, 5'd4, 0, 0, 5'd0, 0, 5'd0);
        e[0] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd2);
        s[1] = mk(bne(5'd4, 5'd5), 1'b0, 0, 0, 5'd0, 1, 1, 5'd4, 0, 5'd0);
        e[1] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd1);
        s[2] = mk(bne(5'd4, 5'd5), 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd4);
        e[2] = ev(2'b01, 2'b00, 2'b10, 0, 1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            apply(s[i], e[i], $sformatf("load_hazard_%0d", i));
            @(negedge clk);
            want = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL %s: got=%b want=%b", nm, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jr();
        stim_t      s[4];
        logic [9:0] e[4];
        logic [9:0] want;
        string      nm;
        s[0] = mk(jr(5'd31), 1'b0, 0, 0, 5'd0, 1, 1, 5'd31, 0, 5'd0);
        e[0] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd1);
        s[1] = mk(jr(5'd31), 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd31);
        e[1] = ev(2'b01, 2'b00, 2'b11, 0, 1, 2'd0);
        s[2] = mk(jr(5'd31), 1'b1, 1, 0, 5'd31, 0, 0, 5'd0, 0, 5'd0);
        e[2] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd1);
        s[3] = mk(jr(5'd31), 1'b1, 0, 0, 5'd0, 1, 0, 5'd31, 0, 5'd0);
        e[3] = ev(2'b10, 2'b00, 2'b11, 0, 1, 2'd0);
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i], $sformatf("jr_%0d", i));
            @(negedge clk);
            want = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL %s: got=%b want=%b", nm, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t      s[7];
        logic [9:0] e[7];
        logic [9:0] want;
        string      nm;
        s[0] = mk(beq(5'd1, 5'd2), 1'b1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        e[0] = ev(2'b00, 2'b00, 2'b10, 0, 1, 2'd0);
        s[1] = mk(beq(5'd6, 5'd0), 1'b1, 1, 1, 5'd6, 0, 0, 5'd0, 0, 5'd0);
        e[1] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd2);
        s[2] = mk(beq(5'd6, 5'd0), 1'b1, 0, 0, 5'd0, 1, 1, 5'd6, 0, 5'd0);
        e[2] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd1);
        s[3] = mk(beq(5'd6, 5'd0), 1'b1, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'd6);
        e[3] = ev(2'b01, 2'b00, 2'b10, 0, 1, 2'd0);
        s[4] = mk(jmp(c_OP_J, 5'd0), 1'b0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);
        e[4] = ev(2'b00, 2'b00, 2'b01, 0, 1, 2'd0);
        s[5] = mk(bne(5'd2, 5'd3), 1'b0, 1, 0, 5'd3, 0, 0, 5'd0, 0, 5'd0);
        e[5] = ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd1);
        s[6] = mk(bne(5'd2, 5'd3), 1'b0, 0, 0, 5'd0, 1, 0, 5'd3, 0, 5'd0);
        e[6] = ev(2'b00, 2'b10, 2'b10, 0, 1, 2'd0);
        for (int i = 0; i < 7; i++) begin
            apply(s[i], e[i], $sformatf("back_to_back_%0d", i));
            @(negedge clk);
            want = exp_q.pop_front(); nm = name_q.pop_front();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL %s: got=%b want=%b", nm, obs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t      lw_ex, lw_mem, clean;
        logic [9:0] want;
        string      nm;
        lw_ex  = mk(beq(5'd8, 5'd0), 1'b1, 1, 1, 5'd8, 0, 0, 5'd0, 0, 5'd0);
        lw_mem = mk(beq(5'd8, 5'd0), 1'b1, 0, 0, 5'd0, 1, 1, 5'd8, 0, 5'd0);
        clean  = mk(beq(5'd1, 5'd2), 1'b1, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);

        // Reset lands while the load stall shows stall_cnt = 2.
        apply(lw_ex, ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd2), "mid_stall_cnt2");
        @(negedge clk);
        want = exp_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b", nm, obs, want);
        end
        #1 reset = 1'b1;
        exp_q.push_back(10'd0); name_q.push_back("reset_async_cnt2");
        #1;
        want = exp_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b", nm, obs, want);
        end
        @(posedge clk); #1 reset = 1'b0;
        apply(clean, ev(2'b00, 2'b00, 2'b10, 0, 1, 2'd0), "after_reset_beq");
        @(negedge clk);
        want = exp_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b", nm, obs, want);
        end
        @(posedge clk); #1;

        // Short pulse between clock edges must still clear the countdown.
        apply(lw_ex, ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd2), "pulse_setup_cnt2");
        @(negedge clk);
        want = exp_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b", nm, obs, want);
        end
        @(posedge clk); #1;
        apply(lw_mem, ev(2'b00, 2'b00, 2'b00, 1, 0, 2'd1), "pulse_setup_cnt1");
        @(negedge clk);
        want = exp_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b", nm, obs, want);
        end
        #1 reset = 1'b1;
        exp_q.push_back(10'd0); name_q.push_back("reset_pulse_outputs");
        #1;
        want = exp_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b", nm, obs, want);
        end
        reset = 1'b0;
        apply(clean, ev(2'b00, 2'b00, 2'b10, 0, 1, 2'd0), "after_pulse_beq");
        #1;
        want = exp_q.pop_front(); nm = name_q.pop_front();
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b", nm, obs, want);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset        = 1'b1;
        inst         = 32'd0;
        cmp_eq       = 1'b0;
        ex_regWrite  = 1'b0;
        ex_memRead   = 1'b0;
        ex_rd        = 5'd0;
        mem_regWrite = 1'b0;
        mem_memRead  = 1'b0;
        mem_rd       = 5'd0;
        wb_regWrite  = 1'b0;
        wb_rd        = 5'd0;
        @(posedge clk); #1;
        test_reset();
        test_no_hazard();
        test_forwarding();
        test_alu_hazard();
        test_load_hazard();
        test_jr();
        test_back_to_back();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
